// File: rtl/jtframe_rstcen_seq.sv
// jtframe_rstcen_seq: fractional clock-enable generator and per-channel reset
// sequencer for the game clock domain.
//   clk        system clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   pll_locked asynchronous PLL lock, two-flop synchronised internally
//   game_rst   request to re-run the HOLD/RELEASE sequence
//   num, den   per-channel ratio, channel i at [i*W +: W], latched on lock
//   cen        per-channel 1-cycle enable pulses at rate num/den
//   rst_out    per-channel active-high reset, released on the channel's cen
//   ready      high once every channel is out of reset
module jtframe_rstcen_seq #(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 10,
  parameter int unsigned LOCKW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pll_locked,
  input  logic            game_rst,
  input  logic [CH*W-1:0] num,
  input  logic [CH*W-1:0] den,
  output logic [CH-1:0]   cen,
  output logic [CH-1:0]   rst_out,
  output logic            ready
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] HOLD      = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  logic             lk_meta_q, lk_q;
  logic [1:0]       state_q, state_d;
  logic [LOCKW-1:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]       hold_cnt_q, hold_cnt_d;
  logic [W-1:0]     num_q [CH];
  logic [W-1:0]     num_d [CH];
  logic [W-1:0]     den_q [CH];
  logic [W-1:0]     den_d [CH];
  logic [W:0]       acc_q [CH];
  logic [W:0]       acc_d [CH];
  logic [W:0]       acc_run [CH];
  logic [W:0]       sum [CH];
  logic [CH-1:0]    cen_run, dis;
  logic [CH-1:0]    cen_q, cen_d;
  logic [CH-1:0]    rst_q, rst_d;
  logic             ready_q, ready_d;

  // Per-channel fractional accumulator; acc < den always holds, so W+1 bits
  // never overflow. num >= den clamps to a constant enable.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      dis[i]     = (num_q[i] == '0) || (den_q[i] == '0);
      sum[i]     = {1'b0, num_q[i]} + acc_q[i];
      cen_run[i] = 1'b0;
      acc_run[i] = acc_q[i];
      if (dis[i]) begin
        acc_run[i] = acc_q[i];
      end else if (num_q[i] >= den_q[i]) begin
        cen_run[i] = 1'b1;
        acc_run[i] = '0;
      end else if (sum[i] >= {1'b0, den_q[i]}) begin
        cen_run[i] = 1'b1;
        acc_run[i] = sum[i] - {1'b0, den_q[i]};
      end else begin
        acc_run[i] = sum[i];
      end
    end
  end

  // Priority: lock loss > game_rst > normal sequencing (rst handled in the flops).
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    num_d      = num_q;
    den_d      = den_q;
    acc_d      = acc_q;
    cen_d      = '0;
    rst_d      = rst_q;
    ready_d    = ready_q;
    if (!lk_q) begin
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      rst_d      = '1;
      ready_d    = 1'b0;
    end else if (state_q == WAIT_LOCK) begin
      rst_d   = '1;
      ready_d = 1'b0;
      if (lock_cnt_q == '1) begin
        state_d    = HOLD;
        lock_cnt_d = '0;
        hold_cnt_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
          num_d[i] = num[i*W +: W];
          den_d[i] = den[i*W +: W];
          acc_d[i] = '0;
        end
      end else begin
        lock_cnt_d = lock_cnt_q + LOCKW'(1);
      end
    end else begin
      acc_d = acc_run;
      cen_d = cen_run;
      if (game_rst) begin
        state_d    = HOLD;
        hold_cnt_d = '0;
        rst_d      = '1;
        ready_d    = 1'b0;
      end else begin
        case (state_q)
          HOLD: begin
            if (hold_cnt_q == 4'd15) state_d = RELEASE;
            else hold_cnt_d = hold_cnt_q + 4'd1;
          end
          RELEASE: begin
            if (rst_q == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              // a channel leaves reset on its first enable; disabled ones at once
              rst_d = rst_q & ~(cen_run | dis);
            end
          end
          default: ready_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lk_meta_q  <= 1'b0;
      lk_q       <= 1'b0;
      state_q    <= WAIT_LOCK;
      lock_cnt_q <= '0;
      hold_cnt_q <= '0;
      for (int unsigned i = 0; i < CH; i++) begin
        num_q[i] <= '0;
        den_q[i] <= '0;
        acc_q[i] <= '0;
      end
      cen_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      lk_meta_q  <= pll_locked;
      lk_q       <= lk_meta_q;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      num_q      <= num_d;
      den_q      <= den_d;
      acc_q      <= acc_d;
      cen_q      <= cen_d;
      rst_q      <= rst_d;
      ready_q    <= ready_d;
    end
  end

  assign cen     = cen_q;
  assign rst_out = rst_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_jtframe_rstcen_seq.sv
// Testbench for jtframe_rstcen_seq: scenario tasks compared against a
// behavioural model (closed-form enable rate, event-counted sequencing).
module tb_jtframe_rstcen_seq;
  localparam int unsigned CH = 4, W = 10, LOCKW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pll_locked = 1'b0;
  logic            game_rst = 1'b0;
  logic [CH*W-1:0] num = '0, den = '0;
  logic [CH-1:0]   cen, rst_out;
  logic            ready;

  int unsigned n_cmp = 0, n_bad = 0;

  jtframe_rstcen_seq #(.CH(CH), .W(W), .LOCKW(LOCKW)) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .game_rst(game_rst),
    .num(num), .den(den), .cen(cen), .rst_out(rst_out), .ready(ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned     m_num [CH];
  int unsigned     m_den [CH];
  longint unsigned m_k = 0;
  logic            m_s1 = 1'b0, m_lk = 1'b0, m_lk_old;
  int              m_phase = 0, m_stable = 0, m_hold = 0;
  logic [CH-1:0]   exp_cen = '0, exp_rst = '1;
  logic            exp_ready = 1'b0;

  // enable on active edge k iff floor(k*n/d) steps up
  function automatic logic rate(int unsigned n, int unsigned d, longint unsigned k);
    if (n == 0 || d == 0) return 1'b0;
    if (n >= d) return 1'b1;
    return ((k * n) / d) != (((k - 1) * n) / d);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_s1 = 1'b0; m_lk = 1'b0; m_phase = 0; m_stable = 0; m_hold = 0; m_k = 0;
      exp_cen = '0; exp_rst = '1; exp_ready = 1'b0;
    end else begin
      m_lk_old = m_lk; m_lk = m_s1; m_s1 = pll_locked;
      if (!m_lk_old) begin
        m_phase = 0; m_stable = 0; exp_cen = '0; exp_rst = '1; exp_ready = 1'b0;
      end else if (m_phase == 0) begin
        exp_cen = '0; exp_rst = '1; exp_ready = 1'b0;
        if (m_stable == (1 << LOCKW) - 1) begin
          for (int i = 0; i < CH; i++) begin
            m_num[i] = num[i*W +: W];
            m_den[i] = den[i*W +: W];
          end
          m_k = 0; m_phase = 1; m_hold = 0; m_stable = 0;
        end else m_stable++;
      end else begin
        m_k++;
        for (int i = 0; i < CH; i++) exp_cen[i] = rate(m_num[i], m_den[i], m_k);
        if (game_rst) begin
          m_phase = 1; m_hold = 0; exp_rst = '1; exp_ready = 1'b0;
        end else if (m_phase == 1) begin
          m_hold++;
          if (m_hold == 16) m_phase = 2;
        end else if (m_phase == 2) begin
          if (exp_rst == '0) begin
            m_phase = 3; exp_ready = 1'b1;
          end else begin
            for (int i = 0; i < CH; i++)
              if (exp_cen[i] || m_num[i] == 0 || m_den[i] == 0) exp_rst[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic rand_cfg();
    for (int i = 0; i < CH; i++) begin
      int unsigned d, n, mode;
      d = $urandom_range(1, 12);
      mode = $urandom_range(0, 9);
      case (mode)
        0: n = 0;
        1: begin n = $urandom_range(1, 9); d = 0; end
        2: n = d + $urandom_range(0, 3);
        default: n = (d == 1) ? 1 : $urandom_range(1, d - 1);
      endcase
      num[i*W +: W] = W'(n);
      den[i*W +: W] = W'(d);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; pll_locked = 1'b1; game_rst = 1'(($urandom_range(0, 1)));
    rand_cfg();
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (cen !== '0) begin n_bad++; $display("FAIL reset_cen got %b want 0", cen); end
      n_cmp++; if (rst_out !== '1) begin n_bad++; $display("FAIL reset_rst got %b want all 1", rst_out); end
      n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", ready); end
    end
    game_rst = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_lockup();
    int first_cen2 = 0, ready_rise = 0, cen0_at_fall = 0;
    int fall [CH];
    for (int i = 0; i < CH; i++) fall[i] = 0;
    num = {10'd0, 10'd5, 10'd3, 10'd1};
    den = {10'd7, 10'd3, 10'd8, 10'd4};
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL lockup_cen edge %0d got %b want %b", n, cen, exp_cen); end
      n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL lockup_rst edge %0d got %b want %b", n, rst_out, exp_rst); end
      n_cmp++; if (ready !== exp_ready) begin n_bad++; $display("FAIL lockup_ready edge %0d got %b want %b", n, ready, exp_ready); end
      if (cen[2] && first_cen2 == 0) first_cen2 = n;
      for (int i = 0; i < CH; i++)
        if (!rst_out[i] && fall[i] == 0) begin
          fall[i] = n;
          if (i == 0) cen0_at_fall = int'(cen[0]);
        end
      if (ready && ready_rise == 0) ready_rise = n;
    end
    n_cmp++; if (first_cen2 != 19) begin n_bad++; $display("FAIL lockup_first_cen got %0d want 19", first_cen2); end
    n_cmp++; if (fall[3] != 35) begin n_bad++; $display("FAIL lockup_disabled_release got %0d want 35", fall[3]); end
    n_cmp++; if (fall[2] != 35) begin n_bad++; $display("FAIL lockup_clamp_release got %0d want 35", fall[2]); end
    n_cmp++; if (fall[1] != 37) begin n_bad++; $display("FAIL lockup_ch1_release got %0d want 37", fall[1]); end
    n_cmp++; if (fall[0] != 38) begin n_bad++; $display("FAIL lockup_ch0_release got %0d want 38", fall[0]); end
    n_cmp++; if (cen0_at_fall != 1) begin n_bad++; $display("FAIL lockup_cen_with_release got %0d want 1", cen0_at_fall); end
    n_cmp++; if (ready_rise != 39) begin n_bad++; $display("FAIL lockup_ready_rise got %0d want 39", ready_rise); end
  endtask

  task automatic test_lock_loss();
    int rst_rise = 0, ready_rise = 0, cen_in_wait = 0;
    @(negedge clk); pll_locked = 1'b0;
    @(negedge clk);
    n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL lockloss_rst edge 1 got %b want %b", rst_out, exp_rst); end
    pll_locked = 1'b1;
    for (int n = 2; n <= 45; n++) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL lockloss_cen edge %0d got %b want %b", n, cen, exp_cen); end
      n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL lockloss_rst edge %0d got %b want %b", n, rst_out, exp_rst); end
      n_cmp++; if (ready !== exp_ready) begin n_bad++; $display("FAIL lockloss_ready edge %0d got %b want %b", n, ready, exp_ready); end
      if (rst_out == '1 && rst_rise == 0) rst_rise = n;
      if (n >= 3 && n <= 19 && cen != '0) cen_in_wait++;
      if (n > 3 && ready && ready_rise == 0) ready_rise = n;
    end
    n_cmp++; if (rst_rise != 3) begin n_bad++; $display("FAIL lockloss_latency got %0d want 3", rst_rise); end
    n_cmp++; if (cen_in_wait != 0) begin n_bad++; $display("FAIL lockloss_cen_in_wait got %0d want 0", cen_in_wait); end
    n_cmp++; if (ready_rise != 40) begin n_bad++; $display("FAIL lockloss_ready_rise got %0d want 40", ready_rise); end
  endtask

  task automatic test_game_rst();
    int ready_rise = 0;
    repeat ($urandom_range(3, 12)) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL gamerst_pre_cen got %b want %b", cen, exp_cen); end
    end
    game_rst = 1'b1;
    @(negedge clk);
    game_rst = 1'b0;
    n_cmp++; if (rst_out !== '1) begin n_bad++; $display("FAIL gamerst_rst_next got %b want all 1", rst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL gamerst_ready_next got %b want 0", ready); end
    for (int n = 2; n <= 45; n++) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL gamerst_cen edge %0d got %b want %b", n, cen, exp_cen); end
      n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL gamerst_rst edge %0d got %b want %b", n, rst_out, exp_rst); end
      n_cmp++; if (ready !== exp_ready) begin n_bad++; $display("FAIL gamerst_ready edge %0d got %b want %b", n, ready, exp_ready); end
      if (ready && ready_rise == 0) ready_rise = n;
    end
    n_cmp++; if (ready_rise < 19 || ready_rise > 45) begin n_bad++; $display("FAIL gamerst_ready_rise got %0d want 19..45", ready_rise); end
  endtask

  task automatic test_config_change();
    int pulses = 0;
    rand_cfg();
    @(negedge clk);
    repeat (32) begin
      @(negedge clk);
      if (cen[0]) pulses++;
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL cfg_hold_cen got %b want %b", cen, exp_cen); end
    end
    n_cmp++; if (pulses != 8) begin n_bad++; $display("FAIL cfg_old_rate got %0d want 8", pulses); end
    @(negedge clk); pll_locked = 1'b0;
    @(negedge clk); pll_locked = 1'b1;
    repeat (70) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL cfg_new_cen got %b want %b", cen, exp_cen); end
      n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL cfg_new_rst got %b want %b", rst_out, exp_rst); end
      n_cmp++; if (ready !== exp_ready) begin n_bad++; $display("FAIL cfg_new_ready got %b want %b", ready, exp_ready); end
    end
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_timeout got %b want 1", ready); end
  endtask

  task automatic test_random();
    int drop = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      n_cmp++; if (cen !== exp_cen) begin n_bad++; $display("FAIL rand_cen cycle %0d got %b want %b", n, cen, exp_cen); end
      n_cmp++; if (rst_out !== exp_rst) begin n_bad++; $display("FAIL rand_rst cycle %0d got %b want %b", n, rst_out, exp_rst); end
      n_cmp++; if (ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready cycle %0d got %b want %b", n, ready, exp_ready); end
      game_rst = ($urandom_range(0, 24) == 0);
      if (drop > 0) drop--;
      else if ($urandom_range(0, 79) == 0) drop = $urandom_range(1, 3);
      pll_locked = (drop == 0);
      if ($urandom_range(0, 59) == 0) rand_cfg();
    end
    game_rst = 1'b0; pll_locked = 1'b1;
  endtask

  task automatic test_simul();
    @(negedge clk);
    rst = 1'b1; game_rst = 1'b1; pll_locked = 1'b0;
    @(negedge clk);
    n_cmp++; if (cen !== '0) begin n_bad++; $display("FAIL simul_cen got %b want 0", cen); end
    n_cmp++; if (rst_out !== '1) begin n_bad++; $display("FAIL simul_rst got %b want all 1", rst_out); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL simul_ready got %b want 0", ready); end
    rst = 1'b0; game_rst = 1'b0; pll_locked = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (rst_out !== '1) begin n_bad++; $display("FAIL simul_after_rst got %b want all 1", rst_out); end
      n_cmp++; if (cen !== '0) begin n_bad++; $display("FAIL simul_after_cen got %b want 0", cen); end
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_lock_loss();
    test_game_rst();
    test_config_change();
    test_random();
    test_simul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
